decoder_rr_arbiter: RTL and testbench

DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

---
 rtl/decoder_rr_arbiter.sv | 91 +++++++++
 tb/tb_decoder_rr_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter with a per-grant hold limit. Grant, index and
// busy are all registered; gnt is the one-hot decode of idx while busy.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       busy
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;

    logic [1:0] base;
    logic [1:0] pick;
    logic [1:0] cand;
    logic [3:0] dec;
    logic       any;
    logic       keep;

    // In GRANT the next arbitration always starts one past the current holder,
    // which is exactly the pointer value that gets written on that edge.
    always_comb begin
        base = (state == ST_GRANT) ? idx + 2'd1 : ptr;
        pick = base;
        cand = base;
        for (int i = 3; i >= 0; i--) begin
            cand = base + 2'(i);
            if (req[cand]) pick = cand;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dec
        assign dec[g] = (pick == 2'(g));
    end

    assign any  = |req;
    assign keep = req[idx] && (cnt != HOLD_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= 2'd0;
            idx   <= 2'd0;
            gnt   <= 4'd0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        idx   <= pick;
                        gnt   <= dec;
                        busy  <= 1'b1;
                        cnt   <= CW'(1);
                        state <= ST_GRANT;
                    end
                end
                default: begin
                    if (keep) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        // release or timeout: rotate, then re-arbitrate in the same edge
                        ptr <= idx + 2'd1;
                        if (any) begin
                            idx <= pick;
                            gnt <= dec;
                            cnt <= CW'(1);
                        end else begin
                            gnt   <= 4'd0;
                            busy  <= 1'b0;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: three hold limits (8, 4, 1) share req/rst and
// are compared each cycle against a queue-free priority-rotation model.
module tb_decoder_rr_arbiter;

    logic            clk;
    logic            rst;
    logic [3:0]      req;
    logic [2:0][3:0] gnt_a;
    logic [2:0][1:0] idx_a;
    logic [2:0]      busy_a;

    int checks = 0;
    int errors = 0;

    int lim   [3] = '{8, 4, 1};
    int m_ptr [3];
    int m_own [3];
    int m_cnt [3];
    int m_idx [3];

    decoder_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a[0]), .idx(idx_a[0]), .busy(busy_a[0]));
    decoder_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a[1]), .idx(idx_a[1]), .busy(busy_a[1]));
    decoder_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a[2]), .idx(idx_a[2]), .busy(busy_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ptr[k] = 0; m_own[k] = -1; m_cnt[k] = 0; m_idx[k] = 0;
        end
    endtask

    // Owner -1 means idle. Hold ends when the owner drops or has used its limit.
    task automatic model_step(input int k, input logic [3:0] r);
        int  base;
        bit  arb;
        base = m_ptr[k];
        arb  = 1'b1;
        if (m_own[k] >= 0) begin
            if (r[m_own[k]] && m_cnt[k] < lim[k]) begin
                m_cnt[k]++;
                arb = 1'b0;
            end else begin
                m_ptr[k] = (m_own[k] + 1) % 4;
                base = m_ptr[k];
            end
        end
        if (arb) begin
            m_own[k] = -1;
            for (int j = 0; j < 4; j++)
                if (m_own[k] < 0 && r[(base + j) % 4]) m_own[k] = (base + j) % 4;
            if (m_own[k] >= 0) begin
                m_idx[k] = m_own[k];
                m_cnt[k] = 1;
            end else begin
                m_cnt[k] = 0;
            end
        end
    endtask

    task automatic cmp_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gnt%0d", k), gnt_a[k], (m_own[k] < 0) ? 0 : (1 << m_own[k]));
            chk($sformatf("busy%0d", k), busy_a[k], (m_own[k] >= 0) ? 1 : 0);
            chk($sformatf("idx%0d", k), idx_a[k], m_idx[k]);
            chk($sformatf("onehot%0d", k), $onehot0(gnt_a[k]), 1);
        end
    endtask

    // Called at a negedge: apply req, take one rising edge, check at the next negedge.
    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        if (!rst) for (int k = 0; k < 3; k++) model_step(k, r);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic rst_pulse();
        #2 rst = 1'b1;
        model_reset();
        #1 cmp_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'd0;
        model_reset();
        @(negedge clk);

        // held in reset with every request up
        repeat (5) begin
            cycle(4'b1111);
            chk("rst_gnt", gnt_a[0], 4'b0000);
            chk("rst_busy", busy_a[0], 0);
            chk("rst_idx", idx_a[0], 2'b00);
        end
        rst = 1'b0;

        // back-to-back handoff then idle
        cycle(4'b0101); chk("hand_g0", gnt_a[0], 4'b0001); chk("hand_i0", idx_a[0], 0);
        cycle(4'b0100); chk("hand_g2", gnt_a[0], 4'b0100); chk("hand_i2", idx_a[0], 2);
        cycle(4'b0000); chk("hand_g", gnt_a[0], 4'b0000); chk("hand_b", busy_a[0], 0);

        // full contention: limit 8 rotates every 8 edges, limit 1 every edge
        rst_pulse();
        for (int n = 0; n < 33; n++) begin
            cycle(4'b1111);
            chk("rot8", gnt_a[0], 4'b0001 << ((n / 8) % 4));
            chk("rot1", gnt_a[2], 4'b0001 << (n % 4));
            chk("rot_busy", busy_a[0], 1);
        end

        // sole requester with limit 4 is re-granted on every timeout
        rst_pulse();
        repeat (20) begin
            cycle(4'b1000);
            chk("solo_g", gnt_a[1], 4'b1000);
            chk("solo_b", busy_a[1], 1);
        end

        // asynchronous reset mid-grant, then pointer restarts at 0
        rst_pulse();
        cycle(4'b0010); chk("ar_pre", gnt_a[0], 4'b0010);
        #2 rst = 1'b1;
        model_reset();
        #1 chk("ar_gnt", gnt_a[0], 4'b0000); chk("ar_busy", busy_a[0], 0);
        @(negedge clk);
        cycle(4'b0011); chk("ar_hold", gnt_a[0], 4'b0000);
        rst = 1'b0;
        cycle(4'b0011); chk("ar_post", gnt_a[0], 4'b0001);

        // holder drops while another raises on the same edge
        rst_pulse();
        cycle(4'b0001); cycle(4'b0001);
        chk("sw_pre", gnt_a[0], 4'b0001);
        cycle(4'b0010); chk("sw_g", gnt_a[0], 4'b0010); chk("sw_i", idx_a[0], 1);

        // random traffic with sticky requests and occasional async resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) rst_pulse();
            if ($urandom_range(0, 3) == 0) cycle(4'($urandom_range(0, 15)));
            else cycle(req);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
